serial_add_ctrl: RTL and testbench

//   Sequencer wrapping a 1-bit serial full-adder stage to add two WIDTH-bit operands LSB-first.

---
 rtl/serial_add_ctrl_if.sv | 17 +
 rtl/serial_add_ctrl.sv | 68 ++++++
 tb/tb_serial_add_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result handshake bundle for the serial adder controller
// Signals: in_valid/in_ready/a/b/cin carry operands in; out_valid/out_ready/sum/cout/ovf carry the result out.
// master: producer/consumer side; slave: controller side.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first serial adder sequencer with valid/ready operand and result handshakes
// Ports: clk rising-edge clock; reset async active-low; clear sync abort (active-high);
// busy high while shifting; bus (slave) carries a/b/cin in and sum/cout/ovf out.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic busy,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state, state_n;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_r;
  logic [CNT_W-1:0]   cnt;
  logic               c, cout_r, ovf_r;
  logic               s, c_n, last;
  assign s    = a_sh[0] ^ b_sh[0] ^ c;
  assign c_n  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign busy          = state == SHIFT;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  always_comb begin
    state_n = clear                              ? IDLE  :
              (state == IDLE  && bus.in_valid)   ? SHIFT :
              (state == SHIFT && last)           ? DONE  :
              (state == DONE  && bus.out_ready)  ? IDLE  : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (clear) begin
        cnt <= '0;
        c   <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        c    <= bus.cin;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        sum_r <= {s, sum_r[WIDTH-1:1]};
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        c     <= c_n;
        cnt   <= last ? '0 : cnt + CNT_W'(1);
        if (last) begin
          cout_r <= c_n;
          ovf_r  <= c ^ c_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the serial adder controller at WIDTH=8
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n;
  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .clear(clear), .busy(busy), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int k = 0;
    bus.a = ta;
    bus.b = tb;
    bus.cin = tc;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 30) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask
  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after_take", bus.in_ready, 1);
  endtask
  task automatic dir_op(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
    start_op(ta, tb, tc);
    wait_out(n);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"}, bus.ovf, eo);
    take();
  endtask
  initial begin
    logic [7:0] ra, rb, es, held;
    logic       rc, ec, eo, seen;
    logic [8:0] full;
    int         prev;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 1);
    dir_op("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    dir_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    dir_op("t2b", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    dir_op("t3a", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    dir_op("t3b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    start_op(8'h12, 8'h34, 1'b1);
    wait_out(n);
    chk("t4_lat", n, 8);
    chk("t4_sum", bus.sum, 8'h47);
    held = bus.sum;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a = 8'hAA;
      bus.b = 8'h55;
      @(posedge clk); #1;
      chk("t4_hold_sum", bus.sum, held);
      chk("t4_hold_cout", bus.cout, 0);
      chk("t4_hold_valid", bus.out_valid, 1);
      chk("t4_hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    take();
    chk("t4_out_valid_low", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("t4_no_queue", busy, 0);
    start_op(8'h55, 8'h55, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("t5_rst_out_valid", bus.out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_sum", bus.sum, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    dir_op("t5_after", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    start_op(8'h33, 8'h44, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("t5_clr_in_ready", bus.in_ready, 1);
    chk("t5_clr_busy", busy, 0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("t5_clr_no_valid", seen, 0);
    dir_op("t5_clr_after", 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      es = full[7:0];
      ec = full[8];
      eo = (ra[7] ~^ rb[7]) & (es[7] ^ ra[7]);
      start_op(ra, rb, rc);
      if (i > 0) chk("t6_period", acc_cyc - prev, 10);
      prev = acc_cyc;
      wait_out(n);
      chk("t6_lat", n, 8);
      chk("t6_result", {eo, bus.cout, bus.sum}, {eo, ec, es});
      chk("t6_ovf", bus.ovf, eo);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("t6_idle_end", bus.in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
